// File: rtl/song_reader_pkg.sv
// song_defs: song entry layout, reader state encoding and sizing shared with song_rom tooling and note_player
package song_defs;
  localparam int SONG_LEN = 32;
  localparam int NUM_VOICES = 3;
  localparam int IDX_W = $clog2(SONG_LEN);
  localparam int ADV_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB = 8;
  localparam int DUR_LSB = 3;
  localparam int DUR_W = DUR_MSB - DUR_LSB + 1;
  localparam logic [5:0] NOTE_REST = 6'd0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WAIT_BEATS, S_DONE} state_t;
endpackage

// File: rtl/song_reader_beat_countdown.sv
// beat_countdown: loadable beat counter that decrements on enabled beats and flags zero
//   clk, rst   : clock, async active-high reset
//   i_clr      : force count to 0 (highest priority)
//   i_load     : load i_dur
//   i_en       : decrement this cycle (beat pulse while counting)
//   o_zero     : count is 0
//   o_expire   : this enabled beat takes the count from 1 to 0
module beat_countdown
  import song_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_dur,
  input  logic             i_en,
  output logic             o_zero,
  output logic             o_expire
);
  logic [DUR_W-1:0] r_cnt;
  assign o_zero = r_cnt == '0;
  assign o_expire = i_en && r_cnt == DUR_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_load) r_cnt <= i_dur;
    else if (i_en && !o_zero) r_cnt <= r_cnt - DUR_W'(1);
endmodule

// File: rtl/song_reader.sv
// song_reader: walks one song out of song_rom and issues note-start commands on rotating voices
//   clk, reset        : clock, async active-high reset
//   play, song, beat  : run level, song select, one-cycle beat pulse
//   rom_addr/rom_dout : {song, index} to song_rom, data back one clock later
//   new_note, note, duration, voice : dispatch pulse with held note fields
//   song_done         : one-cycle pulse after the last entry
module song_reader
  import song_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        beat,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        new_note,
  output logic [5:0]  note,
  output logic [5:0]  duration,
  output logic [1:0]  voice,
  output logic        song_done
);
  state_t           r_state, w_after;
  logic [IDX_W-1:0] r_index;
  logic [1:0]       r_song_q, r_vcnt, r_voice, w_vnext;
  logic [5:0]       r_note, r_dur, w_note;
  logic [DUR_W-1:0] w_dur;
  logic [2:0]       w_unused;
  logic             r_new, r_done, w_adv, w_change, w_load, w_expire, w_zero;
  assign w_adv = rom_dout[ADV_BIT];
  assign w_note = rom_dout[NOTE_MSB:NOTE_LSB];
  assign w_dur = rom_dout[DUR_MSB:DUR_LSB];
  assign w_unused = rom_dout[2:0];
  assign w_change = r_state != S_IDLE && song != r_song_q;
  assign w_load = r_state == S_DECODE && play && !w_change && w_adv && w_dur != '0;
  // leaving the last entry wraps the index to 0 and ends the song
  assign w_after = r_index == IDX_W'(SONG_LEN - 1) ? S_DONE : S_FETCH;
  assign w_vnext = r_vcnt == 2'(NUM_VOICES - 1) ? 2'd0 : r_vcnt + 2'd1;
  assign rom_addr = {song, r_index};
  assign new_note = r_new;
  assign note = r_note;
  assign duration = r_dur;
  assign voice = r_voice;
  assign song_done = r_done;
  beat_countdown u_beats (
    .clk      (clk),
    .rst      (reset),
    .i_clr    (w_change),
    .i_load   (w_load),
    .i_dur    (w_dur),
    .i_en     (r_state == S_WAIT_BEATS && play && beat && !w_change),
    .o_zero   (w_zero),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_song_q <= '0;
      r_vcnt <= '0;
      r_voice <= '0;
      r_note <= '0;
      r_dur <= '0;
      r_new <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_new <= 1'b0;
      r_done <= 1'b0;
      if (w_change) begin
        r_state <= S_IDLE;
        r_index <= '0;
        r_vcnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (play) begin
            r_state <= S_FETCH;
            r_song_q <= song;
          end
          S_FETCH: if (play) r_state <= S_DECODE;
          // a paused decode refetches so stale rom_dout is never used
          S_DECODE: if (!play) r_state <= S_FETCH;
          else begin
            if (w_note != NOTE_REST) begin
              r_new <= 1'b1;
              r_note <= w_note;
              r_dur <= w_dur;
              r_voice <= r_vcnt;
              r_vcnt <= w_vnext;
            end
            if (w_adv) r_vcnt <= '0;
            if (w_load) r_state <= S_WAIT_BEATS;
            else begin
              r_index <= r_index + 1'b1;
              r_state <= w_after;
            end
          end
          S_WAIT_BEATS: if (play && (w_expire || w_zero)) begin
            r_index <= r_index + 1'b1;
            r_state <= w_after;
          end
          S_DONE: begin
            r_done <= 1'b1;
            r_index <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
